// File: rtl/dm_access_unit.sv
// Data-memory access sequencer: one load/store at a time over a req/ack word port,
// with byte-enable/lane-replication on stores and extract/extend on loads.
module dm_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        dmop,
  input  logic              lsign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              align_err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  dmop_q;
  logic        lsign_q;

  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_rep;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val;

  // Request decode from live inputs, used only on the accepting edge
  always_comb begin
    misaligned = 1'b0;
    be_n       = 4'b0000;
    wdata_rep  = wdata;
    unique case (dmop)
      2'b00: begin
        be_n      = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be_n       = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
      end
      2'b11: begin
        misaligned = (addr[1:0] != 2'b00);
        be_n       = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction and extension of returning read data
  always_comb begin
    byte_v = 8'h00;
    half_v = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_val = mem_rdata;
    unique case (lane_q)
      2'd0:    byte_v = mem_rdata[7:0];
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      default: byte_v = mem_rdata[31:24];
    endcase
    unique case (dmop_q)
      2'b00:   ld_val = {{24{lsign_q & byte_v[7]}}, byte_v};
      2'b01:   ld_val = {{16{lsign_q & half_v[15]}}, half_v};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      align_err <= 1'b0;
      rdata     <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= WA_W'(0);
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      lane_q    <= 2'b00;
      dmop_q    <= 2'b00;
      lsign_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done      <= 1'b0;
          align_err <= 1'b0;
          if (req) begin
            busy      <= 1'b1;
            mem_addr  <= addr[ADDR_W-1:2];
            mem_wdata <= wdata_rep;
            lane_q    <= addr[1:0];
            dmop_q    <= dmop;
            lsign_q   <= lsign;
            if (misaligned) begin
              state     <= DONE;
              done      <= 1'b1;
              align_err <= 1'b1;
            end else begin
              state   <= ACCESS;
              mem_req <= 1'b1;
              mem_we  <= we;
              mem_be  <= be_n;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            if (!mem_we) rdata <= ld_val;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          align_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: stores, loads, misalignment, back-pressure, reset.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, we, lsign, mem_ack;
  logic [1:0]  dmop;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, align_err, mem_req, mem_we;
  logic [31:0] rdata, mem_wdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_err = 0;

  dm_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .dmop(dmop), .lsign(lsign),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .align_err(align_err),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] op, input logic ls,
                         input logic [31:0] mr, input logic [3:0] ebe, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; dmop = op; lsign = ls; addr = a;
    tick();
    req = 1'b0;
    chk("ld_mem_req", 32'(mem_req), 32'd1);
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    chk("ld_mem_be", 32'(mem_be), 32'(ebe));
    mem_rdata = mr; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ld_done", 32'(done), 32'd1);
    chk("ld_align_err", 32'(align_err), 32'd0);
    chk("ld_rdata", rdata, exp);
    tick();
    chk("ld_done_clear", 32'(done), 32'd0);
    chk("ld_busy_clear", 32'(busy), 32'd0);
  endtask

  task automatic do_reject(input logic [31:0] a, input logic [1:0] op, input logic w,
                           input logic [31:0] prev);
    req = 1'b1; we = w; dmop = op; addr = a;
    tick();
    req = 1'b0;
    chk("rj_done", 32'(done), 32'd1);
    chk("rj_align_err", 32'(align_err), 32'd1);
    chk("rj_mem_req", 32'(mem_req), 32'd0);
    chk("rj_busy", 32'(busy), 32'd1);
    chk("rj_rdata", rdata, prev);
    tick();
    chk("rj_done_clear", 32'(done), 32'd0);
    chk("rj_mem_req2", 32'(mem_req), 32'd0);
    chk("rj_busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; dmop = 2'b00; lsign = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_align_err", 32'(align_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Byte store with two wait cycles
    req = 1'b1; we = 1'b1; dmop = 2'b00; addr = 32'h1003; wdata = 32'h0000_00AB;
    tick();
    req = 1'b0;
    chk("st_mem_req1", 32'(mem_req), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_be", 32'(mem_be), 32'h8);
    chk("st_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("st_mem_addr", 32'(mem_addr), 32'h400);
    chk("st_busy", 32'(busy), 32'd1);
    chk("st_done0", 32'(done), 32'd0);
    tick();
    chk("st_mem_req2", 32'(mem_req), 32'd1);
    chk("st_done1", 32'(done), 32'd0);
    tick();
    mem_ack = 1'b1;
    chk("st_mem_req3", 32'(mem_req), 32'd1);
    tick();
    mem_ack = 1'b0;
    chk("st_done", 32'(done), 32'd1);
    chk("st_mem_req_off", 32'(mem_req), 32'd0);
    chk("st_mem_be_off", 32'(mem_be), 32'd0);
    chk("st_mem_we_off", 32'(mem_we), 32'd0);
    chk("st_rdata_kept", rdata, 32'h0);
    chk("st_mem_addr_hold", 32'(mem_addr), 32'h400);
    tick();
    chk("st_done_clear", 32'(done), 32'd0);
    chk("st_busy_clear", 32'(busy), 32'd0);

    // Loads
    do_load(32'h2002, 2'b01, 1'b1, 32'h8123_4567, 4'b1100, 32'hFFFF_8123);
    do_load(32'h2001, 2'b00, 1'b0, 32'h1122_F344, 4'b0010, 32'h0000_00F3);
    do_load(32'h2001, 2'b00, 1'b1, 32'h1122_F344, 4'b0010, 32'hFFFF_FFF3);
    do_load(32'h2000, 2'b01, 1'b0, 32'h1234_8765, 4'b0011, 32'h0000_8765);
    do_load(32'h2004, 2'b11, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    // Misaligned requests
    do_reject(32'h0006, 2'b11, 1'b0, 32'hDEAD_BEEF);
    do_reject(32'h0001, 2'b01, 1'b0, 32'hDEAD_BEEF);
    do_reject(32'h0000, 2'b10, 1'b1, 32'hDEAD_BEEF);

    // Stray ack in IDLE, then req held through busy
    mem_ack = 1'b1;
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_done", 32'(done), 32'd0);
    chk("bp_idle_mem_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    req = 1'b1; we = 1'b0; dmop = 2'b11; lsign = 1'b0; addr = 32'h3000;
    tick();
    chk("bp_mem_req", 32'(mem_req), 32'd1);
    mem_rdata = 32'hCAFE_F00D; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_busy_done", 32'(busy), 32'd1);
    tick();
    chk("bp_no_accept_busy", 32'(busy), 32'd0);
    chk("bp_no_accept_req", 32'(mem_req), 32'd0);
    chk("bp_no_extra_done", 32'(done), 32'd0);
    req = 1'b0;
    tick();
    chk("bp_idle2_busy", 32'(busy), 32'd0);
    chk("bp_idle2_done", 32'(done), 32'd0);
    chk("bp_rdata", rdata, 32'hCAFE_F00D);

    // Reset in the middle of an access
    req = 1'b1; we = 1'b1; dmop = 2'b11; addr = 32'h4000; wdata = 32'h55;
    tick();
    req = 1'b0;
    chk("mr_mem_req", 32'(mem_req), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mr_mem_req_drop", 32'(mem_req), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_mem_we", 32'(mem_we), 32'd0);
    chk("mr_mem_be", 32'(mem_be), 32'd0);
    chk("mr_rdata", rdata, 32'h0);
    chk("mr_mem_addr", 32'(mem_addr), 32'h0);
    chk("mr_mem_wdata", mem_wdata, 32'h0);
    chk("mr_done", 32'(done), 32'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_post_done", 32'(done), 32'd0);
      chk("mr_post_mem_req", 32'(mem_req), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Data-memory access sequencer for the multicycle MIPS datapath. Accepts one load/store request at a time from the control FSM, derives byte enables and lane-replicated store data from the low address bits and access size, and drives a word-wide memory port with a variable-latency req/ack handshake. On loads it extracts and sign/zero-extends the addressed lanes into a registered read-data (MDR) output. Misaligned accesses are rejected without touching memory.

## Interface
- ADDR_W, 32, byte-address width (word address is ADDR_W-2 bits)
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- req  in  1  start access; sampled only while busy=0
- we  in  1  1 = store, 0 = load
- dmop  in  2  size: 00 byte, 01 halfword, 11 word, 10 reserved
- lsign  in  1  loads: 1 sign-extend, 0 zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- align_err  out  1  asserted with done when the request was rejected
- rdata  out  32  registered load result
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write strobe (valid with mem_req)
- mem_addr  out  ADDR_W-2  word address = addr[ADDR_W-1:2]
- mem_be  out  4  byte enables (valid with mem_req)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1
- mem_ack  in  1  memory completion

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE, req=1: capture we, dmop, lsign, addr, wdata into internal registers. Misaligned: dmop=10; dmop=01 with addr[0]=1; dmop=11 with addr[1:0]!=0. Misaligned -> DONE with align_err flag set. Otherwise -> ACCESS.
- ACCESS: mem_req=1; mem_we, mem_addr, mem_be, mem_wdata stable from captured values. mem_ack=1 -> DONE. Otherwise stay.
- DONE: done=1, align_err = captured flag; unconditionally -> IDLE.
- Byte enables: byte -> 0001 << addr[1:0]; half -> 0011 if addr[1]=0, 1100 if addr[1]=1; word -> 1111.
- Store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
- Load extract at ack: byte = mem_rdata lane addr[1:0] (bits 8*a+7:8*a); half = bits 31:16 if addr[1] else 15:0; word = all. Extend to 32 bits per lsign. Result registered into rdata on the ack edge.
- rdata changes only on a successful load; unchanged by stores and rejected requests.
- Outside ACCESS: mem_req=0, mem_we=0, mem_be=0000; mem_addr/mem_wdata hold last captured values.
- req while busy=1 is ignored (not queued). mem_ack outside ACCESS is ignored.

## Timing
- Reset (rstn=0, async): state IDLE; busy, done, align_err, mem_req, mem_we = 0; mem_be=0000; rdata, mem_addr, mem_wdata = 0. Reset mid-ACCESS drops mem_req immediately; pending access abandoned, no done.
- Request accepted at edge T: mem_req high from cycle T+1. If mem_ack is sampled high at edge T+1+k (k>=0), done is high during cycle T+2+k and rdata is valid from that cycle. Minimum: done two cycles after acceptance.
- Rejected request accepted at edge T: done=align_err=1 during cycle T+1; mem_req never asserted.
- busy high from cycle after acceptance through the DONE cycle; new req accepted at the edge ending DONE is not possible (busy=1), earliest acceptance is in the first IDLE cycle after done.
- mem_ack in the same cycle mem_req first rises is legal (k=0).

## Test plan
- Reset: assert rstn=0 mid-ACCESS -> mem_req drops same cycle, all outputs at reset values, no done after release.
- Byte store: addr=0x1003, wdata=0x000000AB, dmop=00, we=1, ack after 2 wait cycles -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x400, mem_req high 3 cycles, done 1 cycle later, rdata unchanged.
- Signed half load: addr=0x2002, dmop=01, lsign=1, mem_rdata=0x8123_4567, ack k=0 -> mem_be=1100, rdata=0xFFFF8123, done at T+2.
- Unsigned byte load: addr=0x2001, dmop=00, lsign=0, mem_rdata=0x1122_F344 -> rdata=0x000000F3; same with lsign=1 -> 0xFFFFFFF3.
- Misalignment: word at addr=0x0006, half at 0x0001, dmop=10 -> each gives done=align_err=1 at T+1, mem_req never high, rdata unchanged.
- Back-pressure: req held high during busy and stray mem_ack in IDLE -> exactly one access per IDLE acceptance, no extra done.
